// File: rtl/d_ext_pipe_pkg.sv
// Shared encodings for the immediate-extension pipe.
// Holds ext_op mode codes and the two-entry FIFO state.
package d_ext_pipe_pkg;

  typedef enum logic [2:0] {
    EXT_ZERO = 3'b000,
    EXT_SIGN = 3'b001,
    EXT_HIGH = 3'b010,
    EXT_BR   = 3'b011
  } ext_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_st_e;

endpackage

// File: rtl/d_ext_pipe_ext_unit.sv
// Combinational immediate extender.
// Ports: imm, ext_op in; result, err (illegal op) out.
module ext_unit
  import d_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        ext_op,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [DATA_W-1:0] sext;

  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (1'b1)
      (ext_op == EXT_ZERO):
        result = {{(DATA_W-IMM_W){1'b0}}, imm};
      (ext_op == EXT_SIGN):
        result = sext;
      (ext_op == EXT_HIGH):
        result = {imm, {(DATA_W-IMM_W){1'b0}}};
      (ext_op == EXT_BR):
        result = sext << 2;
      default:
        err = 1'b1;
    endcase
  end

endmodule

// File: rtl/d_ext_pipe.sv
// Immediate extender behind a 2-entry valid/ready FIFO.
// Ports: clk, reset_n, flush, in/out handshakes, ext_imm, op_err, err_cnt.
module d_ext_pipe
  import d_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        ext_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              op_err,
  output logic [CNT_W-1:0]  err_cnt
);

  fifo_st_e          state;
  logic              rdy_q;
  logic [DATA_W-1:0] head_res;
  logic [DATA_W-1:0] tail_res;
  logic              head_err;
  logic              tail_err;
  logic [DATA_W-1:0] new_res;
  logic              new_err;
  logic              accept;
  logic              retire;

  ext_unit #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_ext (
    .imm    (imm),
    .ext_op (ext_op),
    .result (new_res),
    .err    (new_err)
  );

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign ext_imm   = out_valid ? head_res : '0;
  assign op_err    = out_valid && head_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_EMPTY;
      rdy_q    <= 1'b0;
      head_res <= '0;
      tail_res <= '0;
      head_err <= 1'b0;
      tail_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (accept && new_err && !flush && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if (flush) begin
        state <= ST_EMPTY;
      end else begin
        unique case (state)
          ST_EMPTY: begin
            if (accept) begin
              head_res <= new_res;
              head_err <= new_err;
              state    <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (accept && retire) begin
              head_res <= new_res;
              head_err <= new_err;
            end else if (accept) begin
              tail_res <= new_res;
              tail_err <= new_err;
              state    <= ST_FULL;
            end else if (retire) begin
              state <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (retire) begin
              head_res <= tail_res;
              head_err <= tail_err;
              state    <= ST_ONE;
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule
